// File: rtl/result_tx.sv
// Serial result transmitter: captures a 32-bit word on start and sends it as
// uppercase ASCII hex (MS nibble first) over a txdata/txclk/txready byte port, optionally + CR LF.
module result_tx #(
    parameter int NDIG = 8,
    parameter int EOL  = 1
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        txready,
    output logic [7:0]  txdata,
    output logic        txclk,
    output logic        busy,
    output logic        done
);

    localparam int N = NDIG + 2 * EOL;
    localparam logic [3:0] LAST   = 4'(N - 1);
    localparam logic [3:0] NDIG_W = 4'(NDIG);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  txdata_q, txdata_d;
    logic        txclk_q, txclk_d;

    logic [2:0]  sel;
    logic [3:0]  nib;
    logic [7:0]  digit;
    logic [7:0]  chr;

    // Character for the current index: hex digit, then CR, then LF.
    always_comb begin
        sel   = 3'(NDIG - 1) - idx_q[2:0];
        nib   = word_q[{sel, 2'b00} +: 4];
        digit = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        if (idx_q < NDIG_W)
            chr = digit;
        else if (idx_q == NDIG_W)
            chr = 8'h0D;
        else
            chr = 8'h0A;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        word_d   = word_q;
        txdata_d = txdata_q;
        txclk_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d  = value;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (txready) begin
                    txdata_d = chr;
                    txclk_d  = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                // Terminal compare ends the message; the index never wraps.
                if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = SEND;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            word_q   <= '0;
            txdata_q <= '0;
            txclk_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            txdata_q <= txdata_d;
            txclk_q  <= txclk_d;
        end
    end

    assign txdata = txdata_q;
    assign txclk  = txclk_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_result_tx.sv
// Scoreboard bench for result_tx: default build plus an NDIG=4/EOL=0 build.
module tb_result_tx;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    logic        hz100 = 1'b0;
    logic        reset = 1'b1;
    logic        txready = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [31:0] value0 = '0, value1 = '0;
    logic [7:0]  txdata0, txdata1;
    logic        txclk0, txclk1, busy0, busy1, done0, done1;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t q0[$], q1[$];
    int   dq0[$], dq1[$];

    always #5 hz100 = ~hz100;
    always @(posedge hz100) cyc <= cyc + 1;

    result_tx u0 (
        .hz100(hz100), .reset(reset), .start(start0), .value(value0), .txready(txready),
        .txdata(txdata0), .txclk(txclk0), .busy(busy0), .done(done0)
    );

    result_tx #(.NDIG(4), .EOL(0)) u1 (
        .hz100(hz100), .reset(reset), .start(start1), .value(value1), .txready(txready),
        .txdata(txdata1), .txclk(txclk1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_str(input int d, input string s, input int k,
                            input int sat, input int slen, input bit wdone);
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            e.b = s[i];
            e.t = k + 1 + 2 * i + ((i >= sat) ? slen : 0);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (wdone) begin
            if (d == 0) dq0.push_back(k + 2 * s.len() + slen);
            else        dq1.push_back(k + 2 * s.len() + slen);
        end
    endtask

    // Pulse start for one edge; k is the accepting edge number.
    task automatic send(input int d, input logic [31:0] v, output int k);
        @(negedge hz100);
        if (d == 0) begin start0 = 1'b1; value0 = v; end
        else        begin start1 = 1'b1; value1 = v; end
        @(negedge hz100);
        start0 = 1'b0;
        start1 = 1'b0;
        k = cyc;
        chk("busy after accept", (d == 0) ? busy0 : busy1, 1'b1);
    endtask

    task automatic wait_idle(input int d, input int exp_cyc);
        for (int i = 0; i < 300; i++) begin
            @(negedge hz100);
            if (((d == 0) ? busy0 : busy1) == 1'b0) break;
        end
        chk("busy fall cycle", cyc, exp_cyc);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge hz100);
    endtask

    // Monitors: pop expected bytes/done times whenever the DUT strobes.
    always @(negedge hz100) begin
        exp_t e;
        int   t;
        if (txclk0) begin
            if (q0.size() == 0) begin
                checks++;
                $display("FAIL u0 strobe: got unexpected byte %0h expected none (cycle %0d)", txdata0, cyc);
            end else begin
                e = q0.pop_front();
                chk("u0 byte", txdata0, e.b);
                chk("u0 strobe cycle", cyc, e.t);
            end
        end
        if (done0) begin
            if (dq0.size() == 0) begin
                checks++;
                $display("FAIL u0 done: got unexpected pulse expected none (cycle %0d)", cyc);
            end else begin
                t = dq0.pop_front();
                chk("u0 done cycle", cyc, t);
            end
        end
    end

    always @(negedge hz100) begin
        exp_t e;
        int   t;
        if (txclk1) begin
            if (q1.size() == 0) begin
                checks++;
                $display("FAIL u1 strobe: got unexpected byte %0h expected none (cycle %0d)", txdata1, cyc);
            end else begin
                e = q1.pop_front();
                chk("u1 byte", txdata1, e.b);
                chk("u1 strobe cycle", cyc, e.t);
            end
        end
        if (done1) begin
            if (dq1.size() == 0) begin
                checks++;
                $display("FAIL u1 done: got unexpected pulse expected none (cycle %0d)", cyc);
            end else begin
                t = dq1.pop_front();
                chk("u1 done cycle", cyc, t);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t expected finish", $time);
        $fatal(1);
    end

    initial begin
        int k;
        // Reset values, and start during reset is ignored.
        #1;
        chk("rst txdata", txdata0, 8'h00);
        chk("rst txclk", txclk0, 1'b0);
        chk("rst busy", busy0, 1'b0);
        chk("rst done", done0, 1'b0);
        @(negedge hz100);
        start0 = 1'b1;
        value0 = 32'h1234ABCD;
        @(negedge hz100);
        start0 = 1'b0;
        reset  = 1'b0;
        @(negedge hz100);
        chk("start under reset", busy0, 1'b0);

        // Basic message with full timeline.
        send(0, 32'h1234ABCD, k);
        push_str(0, "1234ABCD\r\n", k, 99, 0, 1);
        wait_idle(0, k + 21);

        // All-zero and all-F digits.
        send(0, 32'h00000000, k);
        push_str(0, "00000000\r\n", k, 99, 0, 1);
        wait_idle(0, k + 21);
        send(0, 32'hFFFFFFFF, k);
        push_str(0, "FFFFFFFF\r\n", k, 99, 0, 1);
        wait_idle(0, k + 21);

        // Five-cycle txready stall before character 3.
        send(0, 32'h1234ABCD, k);
        push_str(0, "1234ABCD\r\n", k, 3, 5, 1);
        wait_until(k + 6);
        txready = 1'b0;
        wait_until(k + 9);
        chk("stall txdata hold", txdata0, 8'h33);
        chk("stall txclk low", txclk0, 1'b0);
        wait_until(k + 11);
        txready = 1'b1;
        wait_idle(0, k + 26);

        // Start and value change mid-message are ignored.
        send(0, 32'h1234ABCD, k);
        push_str(0, "1234ABCD\r\n", k, 99, 0, 1);
        wait_until(k + 6);
        start0 = 1'b1;
        value0 = 32'h0;
        @(negedge hz100);
        start0 = 1'b0;
        wait_idle(0, k + 21);
        repeat (8) @(negedge hz100);
        chk("no relaunch", busy0, 1'b0);

        // Reset after character 4 aborts the message asynchronously.
        send(0, 32'h1234ABCD, k);
        push_str(0, "1234A", k, 99, 0, 0);
        wait_until(k + 10);
        chk("pre-abort txdata", txdata0, 8'h41);
        reset = 1'b1;
        #1;
        chk("abort txdata", txdata0, 8'h00);
        chk("abort txclk", txclk0, 1'b0);
        chk("abort busy", busy0, 1'b0);
        chk("abort done", done0, 1'b0);
        repeat (2) @(negedge hz100);
        reset = 1'b0;
        repeat (6) @(negedge hz100);
        chk("idle after abort", busy0, 1'b0);
        send(0, 32'h1234ABCD, k);
        push_str(0, "1234ABCD\r\n", k, 99, 0, 1);
        wait_idle(0, k + 21);

        // Four digits, no line ending.
        send(1, 32'hFFFFBEEF, k);
        push_str(1, "BEEF", k, 99, 0, 1);
        wait_idle(1, k + 9);

        repeat (4) @(negedge hz100);
        chk("u0 bytes left", q0.size(), 0);
        chk("u0 done left", dq0.size(), 0);
        chk("u1 bytes left", q1.size(), 0);
        chk("u1 done left", dq1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
